// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, port owner encoding
// and funct3-style access width codes.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IMEM = 1'b0,
        OWN_DMEM = 1'b1
    } owner_e;

    localparam logic [2:0] BYTE   = 3'b000;
    localparam logic [2:0] HALF   = 3'b001;
    localparam logic [2:0] WORD   = 3'b010;
    localparam logic [2:0] BYTE_U = 3'b100;
    localparam logic [2:0] HALF_U = 3'b101;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational grant between the fetch and data ports.
// MEM_ARB_RR_EN selects round-robin on ties; otherwise dmem has fixed priority.
module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  logic   imem_valid,
    input  logic   dmem_valid,
`ifdef MEM_ARB_RR_EN
    input  owner_e last_grant,
`endif
    output logic   grant_imem,
    output logic   grant_dmem
);

    always_comb begin
        grant_imem = 1'b0;
        grant_dmem = 1'b0;
`ifdef MEM_ARB_RR_EN
        if (imem_valid && dmem_valid) begin
            // on a tie the port that did not win last time goes first
            if (last_grant == OWN_IMEM) begin
                grant_dmem = 1'b1;
            end else begin
                grant_imem = 1'b1;
            end
        end else begin
            grant_imem = imem_valid;
            grant_dmem = dmem_valid;
        end
`else
        grant_dmem = dmem_valid;
        grant_imem = imem_valid && !dmem_valid;
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between the fetch and data ports,
// one access at a time. Optional round-robin arbitration via MEM_ARB_RR_EN.
//
// state | meaning
// IDLE  | arbitrate; winner's req_ready is high, accept latches the request
// ISSUE | mem_en high for one cycle with the latched request on mem_*
// WAIT  | MEM_LAT cycles; last one captures mem_data_out into owner's resp_data
// RESP  | one-cycle resp_valid pulse on the owning port
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              imem_req_valid,
    input  logic [ADDR_W-1:0] imem_req_addr,
    output logic              imem_req_ready,
    output logic              imem_resp_valid,
    output logic [DATA_W-1:0] imem_resp_data_in,
    input  logic              dmem_req_valid,
    input  logic [ADDR_W-1:0] dmem_req_addr,
    input  logic              dmem_req_write_enable,
    input  logic [DATA_W-1:0] dmem_req_write_data,
    input  logic [2:0]        dmem_req_data_width,
    output logic              dmem_req_ready,
    output logic              dmem_resp_valid,
    output logic [DATA_W-1:0] dmem_resp_data_in,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write_enable,
    output logic [DATA_W-1:0] mem_write_data,
    output logic [2:0]        mem_data_width,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    state_e           state;
    state_e           state_next;
    owner_e           owner;
    logic [CNT_W-1:0] wait_cnt;
    logic             wait_done;
    logic             grant_imem;
    logic             grant_dmem;
    logic             accept_imem;
    logic             accept_dmem;
    logic             accept;

`ifdef MEM_ARB_RR_EN
    owner_e           last_grant;
`endif

    mem_arb_grant u_grant (
        .imem_valid (imem_req_valid),
        .dmem_valid (dmem_req_valid),
`ifdef MEM_ARB_RR_EN
        .last_grant (last_grant),
`endif
        .grant_imem (grant_imem),
        .grant_dmem (grant_dmem)
    );

    assign wait_done = (wait_cnt == CNT_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        accept_imem = 1'b0;
        accept_dmem = 1'b0;
        case (state)
            IDLE: begin
                accept_imem = imem_req_valid && grant_imem;
                accept_dmem = dmem_req_valid && grant_dmem;
                if (accept_imem || accept_dmem) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (wait_done) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign accept = accept_imem || accept_dmem;

    // Ready is masked during reset only at the port; the flops ignore accept then.
    assign imem_req_ready  = accept_imem && !reset;
    assign dmem_req_ready  = accept_dmem && !reset;
    assign imem_resp_valid = (state == RESP) && (owner == OWN_IMEM);
    assign dmem_resp_valid = (state == RESP) && (owner == OWN_DMEM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner             <= OWN_IMEM;
            wait_cnt          <= '0;
            mem_en            <= 1'b0;
            mem_addr          <= '0;
            mem_write_enable  <= 1'b0;
            mem_write_data    <= '0;
            mem_data_width    <= '0;
            imem_resp_data_in <= '0;
            dmem_resp_data_in <= '0;
        end else begin
            // mem_* double as the latched request, so mem_en lines up with ISSUE
            mem_en <= accept;
            if (accept) begin
                owner            <= accept_dmem ? OWN_DMEM : OWN_IMEM;
                mem_addr         <= accept_dmem ? dmem_req_addr : imem_req_addr;
                mem_write_enable <= accept_dmem && dmem_req_write_enable;
                mem_write_data   <= accept_dmem ? dmem_req_write_data : '0;
                mem_data_width   <= accept_dmem ? dmem_req_data_width : WORD;
            end
            if (state == ISSUE) begin
                wait_cnt <= CNT_W'(MEM_LAT);
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - CNT_W'(1);
            end
            if ((state == WAIT) && wait_done) begin
                if (owner == OWN_IMEM) begin
                    imem_resp_data_in <= mem_data_out;
                end else begin
                    dmem_resp_data_in <= mem_write_enable ? '0 : mem_data_out;
                end
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= OWN_IMEM;
        end else if (accept) begin
            last_grant <= accept_dmem ? OWN_DMEM : OWN_IMEM;
        end
    end
`endif

endmodule
